// File: rtl/data_mem_io_if.sv
// Data-memory port between the single-cycle core (master) and data_mem_io (slave).
// RD is combinational from A, so the core sees load data in the same cycle.
interface data_mem_io_if;
    logic        MemWrite;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output MemWrite, output A, output WD, input RD);
    modport slave  (input MemWrite, input A, input WD, output RD);
endinterface

// File: rtl/data_mem_io.sv
// Load/store responder: word RAM plus an IO window with GPIO, timer and TX FIFO.
// Define DMEM_TIMER_EN to build the timer (TIMER_COUNT, TIMER_CMP, STATUS.hit, timer_irq).
module data_mem_io #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_io_if.slave  bus,
    output logic [31:0]   gpio_out,
    output logic          timer_irq,
    output logic [31:0]   tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OFF_GPIO   = 6'h00;
    localparam logic [5:0] OFF_COUNT  = 6'h01;
    localparam logic [5:0] OFF_CMP    = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_TX     = 6'h04;

    logic [31:0]   r_mem [RAM_WORDS];
    logic [31:0]   r_gpio;
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic          w_io;
    logic          w_ram;
    logic [AW-1:0] w_idx;
    logic [5:0]    w_off;
    logic          w_wr;
    logic          w_io_wr;
    logic          w_status_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_hit;
    logic [31:0]   w_count_rd;
    logic [31:0]   w_cmp_rd;

    assign w_io        = (bus.A[31:8] == IO_BASE[31:8]);
    assign w_ram       = !w_io && (bus.A[31:AW+2] == '0);
    assign w_idx       = bus.A[AW+1:2];
    assign w_off       = bus.A[7:2];
    // Reset suppresses every store and pop in the cycle it is asserted.
    assign w_wr        = bus.MemWrite && !reset;
    assign w_io_wr     = w_wr && w_io;
    assign w_status_wr = w_io_wr && (w_off == OFF_STATUS);

    always_ff @(posedge clk) begin
        if (w_wr && w_ram)
            r_mem[w_idx] <= bus.WD;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_gpio <= '0;
        else if (w_io_wr && (w_off == OFF_GPIO))
            r_gpio <= bus.WD;
    end
    assign gpio_out = r_gpio;

`ifdef DMEM_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_hit   <= 1'b0;
        end else begin
            r_count <= (w_io_wr && (w_off == OFF_COUNT)) ? bus.WD : r_count + 32'd1;
            if (w_io_wr && (w_off == OFF_CMP))
                r_cmp <= bus.WD;
            // A match in the same cycle as a clear keeps the flag set.
            if (r_count == r_cmp)
                r_hit <= 1'b1;
            else if (w_status_wr && bus.WD[0])
                r_hit <= 1'b0;
        end
    end
    assign w_hit      = r_hit;
    assign w_count_rd = r_count;
    assign w_cmp_rd   = r_cmp;
`else
    assign w_hit      = 1'b0;
    assign w_count_rd = '0;
    assign w_cmp_rd   = '0;
`endif
    assign timer_irq = w_hit;

    assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_pop      = !w_empty && tx_ready && !reset;
    assign w_push_req = w_io_wr && (w_off == OFF_TX);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= bus.WD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - CW'(1);
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            else if (w_status_wr && bus.WD[3])
                r_ovf <= 1'b0;
        end
    end

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? '0 : r_fifo[r_rptr];

    always_comb begin
        bus.RD = '0;
        if (w_ram) begin
            bus.RD = r_mem[w_idx];
        end else if (w_io) begin
            case (w_off)
                OFF_GPIO:   bus.RD = r_gpio;
                OFF_COUNT:  bus.RD = w_count_rd;
                OFF_CMP:    bus.RD = w_cmp_rd;
                OFF_STATUS: bus.RD = {28'd0, r_ovf, w_empty, w_full, w_hit};
                default:    bus.RD = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: RAM, GPIO, timer (or its absence), TX FIFO and reset.
// Build with DMEM_TIMER_EN defined to exercise the timer path.
module tb_data_mem_io;
    localparam logic [31:0] IO   = 32'hFFFF_FF00;
    localparam logic [31:0] GPIO = IO + 32'h00;
    localparam logic [31:0] CNT  = IO + 32'h04;
    localparam logic [31:0] CMP  = IO + 32'h08;
    localparam logic [31:0] STAT = IO + 32'h0C;
    localparam logic [31:0] TXD  = IO + 32'h10;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    int          n_checks;
    int          n_fail;

    data_mem_io_if bus ();

    data_mem_io #(.RAM_WORDS(64), .FIFO_DEPTH(4), .IO_BASE(IO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.A        = addr;
        bus.WD       = data;
        bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.A = addr;
        #1;
        check(tag, bus.RD, exp);
    endtask

    initial begin
        logic seen_irq;
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.MemWrite = 1'b0;
        bus.A        = '0;
        bus.WD       = '0;
        tx_ready     = 1'b0;
        tick();
        tick();

        check("rst_gpio", gpio_out, 32'h0);
        check("rst_txv", {31'd0, tx_valid}, 32'h0);
        check("rst_txd", tx_data, 32'h0);
        check("rst_irq", {31'd0, timer_irq}, 32'h0);
        load_chk("rst_status", STAT, 32'h4);
`ifdef DMEM_TIMER_EN
        load_chk("rst_cmp", CMP, 32'hFFFF_FFFF);
`endif
        reset = 1'b0;

        // RAM region
        store(32'h0000_0010, 32'hDEAD_BEEF);
        load_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        load_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        load_chk("ram_oob", 32'h0000_1000, 32'h0);
        store(32'h0000_0000, 32'h1111_1111);
        store(32'h0000_1000, 32'hBAD0_BAD0);
        load_chk("ram_oob_wr", 32'h0000_0000, 32'h1111_1111);
        store(32'h0000_00FC, 32'hCAFE_F00D);
        load_chk("ram_last", 32'h0000_00FC, 32'hCAFE_F00D);

        // GPIO and unmapped offsets
        store(GPIO, 32'h5A);
        check("gpio_wr", gpio_out, 32'h5A);
        load_chk("gpio_rd", GPIO, 32'h5A);
        store(IO + 32'h14, 32'h1234);
        load_chk("io_unmapped", IO + 32'h14, 32'h0);
        load_chk("tx_rd_zero", TXD, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("gpio_rst", gpio_out, 32'h0);
        load_chk("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

`ifdef DMEM_TIMER_EN
        store(CNT, 32'd10);
        store(CMP, 32'd15);
        load_chk("tmr_count", CNT, 32'd11);
        load_chk("tmr_cmp", CMP, 32'd15);
        repeat (4) tick();
        check("tmr_pre", {31'd0, timer_irq}, 32'h0);
        tick();
        check("tmr_hit", {31'd0, timer_irq}, 32'h1);
        load_chk("tmr_status", STAT, 32'h5);
        store(STAT, 32'h1);
        check("tmr_clr", {31'd0, timer_irq}, 32'h0);
`else
        load_chk("notmr_cnt", CNT, 32'h0);
        store(CNT, 32'd10);
        store(CMP, 32'd10);
        load_chk("notmr_cnt_wr", CNT, 32'h0);
        load_chk("notmr_cmp_wr", CMP, 32'h0);
        seen_irq = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (timer_irq !== 1'b0) seen_irq = 1'b1;
            tick();
        end
        check("notmr_irq", {31'd0, seen_irq}, 32'h0);
`endif

        // FIFO fill past full, then drain
        tx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) store(TXD, 32'(k));
        load_chk("fifo_ovf_status", STAT, 32'hA);
        tx_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_v%0d", k), {31'd0, tx_valid}, 32'h1);
            check($sformatf("drain_d%0d", k), tx_data, 32'(k));
            tick();
        end
        check("drain_empty", {31'd0, tx_valid}, 32'h0);
        check("drain_txd0", tx_data, 32'h0);
        tick();
        load_chk("empty_pop", STAT, 32'hC);
        tx_ready = 1'b0;
        store(STAT, 32'h8);
        load_chk("ovf_clr", STAT, 32'h4);

        // Full FIFO with simultaneous pop and push
        for (int k = 1; k <= 4; k++) store(TXD, 32'(k));
        load_chk("full_status", STAT, 32'h2);
        tx_ready = 1'b1;
        store(TXD, 32'd9);
        tx_ready = 1'b0;
        load_chk("pp_status", STAT, 32'h2);
        check("pp_head", tx_data, 32'd2);
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp_d%0d", k), tx_data, (k == 3) ? 32'd9 : 32'(k + 2));
            tick();
        end
        check("pp_empty", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Empty push: no fall-through
        bus.A = TXD; bus.WD = 32'd7; bus.MemWrite = 1'b1;
        #1;
        check("nofall_pre", {31'd0, tx_valid}, 32'h0);
        tick();
        bus.MemWrite = 1'b0;
        check("nofall_v", {31'd0, tx_valid}, 32'h1);
        check("nofall_d", tx_data, 32'd7);

        // Reset mid-burst ignores the store and the pop in that cycle
        store(TXD, 32'd8);
        store(GPIO, 32'h33);
        check("gpio_33", gpio_out, 32'h33);
        reset = 1'b1; tx_ready = 1'b1;
        bus.A = GPIO; bus.WD = 32'h77; bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0; tx_ready = 1'b0;
        check("rst_mid_gpio", gpio_out, 32'h0);
        check("rst_mid_txv", {31'd0, tx_valid}, 32'h0);
        check("rst_mid_txd", tx_data, 32'h0);
        load_chk("rst_mid_status", STAT, 32'h4);
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_io.md
# data_mem_io

Load/store responder for the single-cycle core: it answers the datapath's data-memory port (address from the ALU result, store data, read data back) within the same cycle. It holds word-addressed data RAM plus a small memory-mapped peripheral window: a GPIO output register, a free-running timer with compare flag, and a TX FIFO drained by an external valid/ready consumer. It sits beside the datapath at top level and is the target end of every load and store the core issues.

## Interface
- RAM_WORDS, 64, data RAM depth in 32-bit words (power of 2)
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- IO_BASE, 32'hFFFF_FF00, peripheral window base; window = A[31:8]==IO_BASE[31:8]

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- MemWrite  in  1  store strobe for current cycle
- A  in  32  byte address (A[1:0] ignored)
- WD  in  32  store data
- RD  out  32  load data, combinational
- gpio_out  out  32  GPIO register
- timer_irq  out  1  timer hit flag
- tx_data  out  32  FIFO head word
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head

## Operation
- RAM region: A[31:8]!=IO_BASE[31:8] and word index A[31:2] < RAM_WORDS. Read: RD = mem[A[$clog2(RAM_WORDS)+1:2]]. Store: written on the edge when MemWrite=1. RAM contents not reset.
- Out-of-range non-IO address: RD=0, store ignored.
- IO offsets (A[7:0]):
  - 0x00 GPIO_OUT RW: store loads gpio_out.
  - 0x04 TIMER_COUNT RW: reads count; store loads WD (wins over increment).
  - 0x08 TIMER_CMP RW.
  - 0x0C STATUS: bit0 hit (sticky), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky); other bits 0. Store with WD[0]=1 clears hit, WD[3]=1 clears overflow.
  - 0x10 TX_DATA WO: store pushes WD; reads return 0.
  - Other offsets: RD=0, store ignored.
- Timer: count+1 every cycle, wraps 32'hFFFF_FFFF→0. When count==cmp, hit sets on next edge. Clear and set in same cycle: set wins. timer_irq = hit.
- FIFO: circular buffer, read/write pointers plus occupancy count. Pop when tx_valid && tx_ready. Push on TX_DATA store. Full with no pop: push dropped, overflow sets. Full with simultaneous pop: push accepted, occupancy unchanged. Empty: pop impossible (tx_valid=0).
- tx_data = head entry; value is don't-care when tx_valid=0 but held at 0 after reset.

## Timing
- Reads: zero latency, combinational from A.
- Stores and pushes: visible one cycle after the edge.
- Empty FIFO push: tx_valid rises the cycle after the store edge, with no fall-through.
- Reset values: gpio_out=0, count=0, cmp=32'hFFFF_FFFF, hit=0, timer_irq=0, overflow=0, FIFO empty, tx_valid=0, tx_data=0.
- RD follows A even during reset: RAM reads return contents, IO reads return reset values.
- Reset asserted mid-burst: FIFO contents discarded and pointers cleared on that edge. Any store or pop in the same cycle is ignored.

## Configuration
- DMEM_TIMER_EN defined: timer, TIMER_COUNT/TIMER_CMP and STATUS.bit0 implemented as above.
- DMEM_TIMER_EN undefined: no timer flops. Offsets 0x04/0x08 read 0, stores there ignored. STATUS.bit0=0, timer_irq tied 0.

## Test plan
- Store 32'hDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 → both RD=32'hDEAD_BEEF. Load 0x0000_1000 (RAM_WORDS=64) → RD=0.
- Store 32'h5A to IO_BASE+0x00 → gpio_out=32'h5A next cycle. Reset → gpio_out=0.
- Store 10 to IO_BASE+0x04, store 15 to IO_BASE+0x08 → hit and timer_irq=1 after count reaches 15. Store 1 to IO_BASE+0x0C → cleared next cycle.
- tx_ready=0, push 1..5 to IO_BASE+0x10 (FIFO_DEPTH=4) → STATUS=0xA (full, overflow). Raise tx_ready → tx_data 1,2,3,4 on consecutive cycles, then tx_valid=0.
- FIFO full, tx_ready=1, push 9 in same cycle → pop of 1 and push of 9 both occur, occupancy stays 4, no overflow; 9 delivered last.
- DMEM_TIMER_EN undefined: load IO_BASE+0x04 → RD=0, timer_irq stays 0 for 100 cycles.
